// File: rtl/popcount_stream_acc_if.sv
// ---------------------------------------------------------------------------
// popcount_stream_acc_if
// Purpose : bundles the input word stream and the frame-total result stream
//           of popcount_stream_acc into one port.
// Handshake: a transfer happens on a rising clock edge where valid and ready
//           are both high. A source that raised valid keeps valid and its
//           data stable until that edge. The sink may drive ready
//           independently of valid.
// Signals :
//   in_data      WIDTH   input word (master -> slave)
//   in_valid     1       in_data/in_last valid (master -> slave)
//   in_last      1       word closes its frame (master -> slave)
//   in_ready     1       slave accepts a word this cycle (slave -> master)
//   out_count    ACC_W   frame total of set bits (slave -> master)
//   out_overflow 1       accumulator overflowed during the frame (slave -> master)
//   out_valid    1       out_count/out_overflow valid (slave -> master)
//   out_ready    1       master accepts the result (master -> slave)
//   dbg_state    2       FSM state register, observation only (slave -> master)
// Modports: master = stream source / result sink, slave = popcount_stream_acc.
// ---------------------------------------------------------------------------
interface popcount_stream_acc_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       dbg_state;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_count, out_overflow, out_valid, dbg_state
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_count, out_overflow, out_valid, dbg_state
    );
endinterface

// File: rtl/popcount_stream_acc.sv
// ---------------------------------------------------------------------------
// popcount_stream_acc
// Purpose : multi-cycle population counter for streamed words. Each accepted
//           WIDTH-bit word is scanned LANES bits per clock (N = WIDTH/LANES
//           SCAN cycles). Set bits accumulate across a frame closed by
//           in_last; the frame total is then offered on the output stream.
// Parameters:
//   WIDTH  input word width (>= 1)
//   LANES  bits examined per SCAN cycle, must divide WIDTH (1..WIDTH)
//   ACC_W  accumulator / out_count width (>= 1)
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high reset; discards any partial frame or
//          pending result
//   bus    popcount_stream_acc_if.slave (see the interface for signals)
// Configuration macro:
//   POPCNT_SATURATE_EN  defined   -> accumulator clamps at 2^ACC_W-1 on
//                                    overflow
//                       undefined -> accumulator wraps modulo 2^ACC_W
//   In both builds out_overflow is a sticky per-frame overflow flag.
// Timing  : handshake in cycle 0, SCAN cycles 1..N, then either IDLE
//           (in_ready=1) or DONE (out_valid=1) in cycle N+1.
// ---------------------------------------------------------------------------
module popcount_stream_acc #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int ACC_W = 16
) (
    input logic                  clk,
    input logic                  reset,
    popcount_stream_acc_if.slave bus
);
    localparam int N      = WIDTH / LANES;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ADD_W  = $clog2(LANES + 1);
    // Sum width: one carry bit above the accumulator, widened further only
    // when a single addend could exceed ACC_W+1 bits (tiny ACC_W).
    localparam int SUM_W  = (ACC_W + 1 > ADD_W + 1) ? ACC_W + 1 : ADD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shift_q;
    logic              last_q;
    logic [BEAT_W-1:0] beat_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;

    logic [ADD_W-1:0]  lane_cnt;
    logic [SUM_W-1:0]  sum;
    logic              carry;
    logic [ACC_W-1:0]  acc_d;
    logic              ovf_d;

    // Accumulator step for one SCAN cycle: popcount of the low LANES bits of
    // the shift register added to the running frame total.
    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_cnt = lane_cnt + ADD_W'(shift_q[i]);
        end
        sum   = SUM_W'(acc_q) + SUM_W'(lane_cnt);
        carry = |sum[SUM_W-1:ACC_W];
        ovf_d = ovf_q | carry;
`ifdef POPCNT_SATURATE_EN
        // Once clamped, every further non-zero addend carries again, so the
        // accumulator stays at the maximum for the rest of the frame.
        acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_d = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone is the handshake.
                    if (bus.in_valid) begin
                        shift_q <= bus.in_data;
                        last_q  <= bus.in_last;
                        beat_q  <= BEAT_W'(N - 1);
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    acc_q   <= acc_d;
                    ovf_q   <= ovf_d;
                    shift_q <= shift_q >> LANES;
                    beat_q  <= beat_q - 1'b1;
                    if (beat_q == '0) begin
                        state_q <= last_q ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    // Result stays on the outputs until it is taken; taking it
                    // starts a fresh frame.
                    if (bus.out_ready) begin
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_DONE);
    assign bus.out_count    = acc_q;
    assign bus.out_overflow = ovf_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// ---------------------------------------------------------------------------
// tb_popcount_stream_acc
// Main instance (WIDTH=8, LANES=2, ACC_W=16) is driven with directed frames
// and checked every cycle against a timeline/frame-sum model; a second
// instance with ACC_W=4 exercises overflow; a generate block sweeps other
// WIDTH/LANES shapes with random frames against a software popcount.
// ---------------------------------------------------------------------------
module tb_popcount_stream_acc;
    localparam int W0 = 8;
    localparam int L0 = 2;
    localparam int A0 = 16;
    localparam int N0 = W0 / L0;
    localparam int A1 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    int sweep_left = 3;

    popcount_stream_acc_if #(.WIDTH(W0), .ACC_W(A0)) bus ();
    popcount_stream_acc #(.WIDTH(W0), .LANES(L0), .ACC_W(A0)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    popcount_stream_acc_if #(.WIDTH(W0), .ACC_W(A1)) bus1 ();
    popcount_stream_acc #(.WIDTH(W0), .LANES(L0), .ACC_W(A1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model of the main instance ----------------
    // Timeline per negedge sample t: a word accepted at sample t keeps the
    // block busy through sample t+N0; at t+N0+1 it is free again, or, for a
    // last word, presents the frame total until out_ready is seen.
    int  t = 0;
    int  free_at = 0;
    int  res_at = 0;
    int  frame_sum = 0;
    bit  pending = 1'b0;
    bit  exp_rdy;
    bit  exp_ov;
    logic [A0:0] exp_q[$];

    function automatic logic [A0:0] frame_result(input int s);
        logic [A0-1:0] c;
        logic          o;
        o = (s >= (1 << A0));
        c = A0'(s);
`ifdef POPCNT_SATURATE_EN
        if (o) c = '1;
`endif
        return {o, c};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pending   = 1'b0;
            frame_sum = 0;
            free_at   = t + 1;
        end else begin
            exp_rdy = (t >= free_at) && !pending;
            exp_ov  = pending && (t >= res_at);
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov && exp_q.size() > 0) begin
                chk("out_count", bus.out_count, exp_q[0][A0-1:0]);
                chk("out_overflow", bus.out_overflow, exp_q[0][A0]);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    pending = 1'b0;
                end
            end
            if (exp_rdy && bus.in_valid) begin
                frame_sum += $countones(bus.in_data);
                free_at = t + N0 + 1;
                if (bus.in_last) begin
                    exp_q.push_back(frame_result(frame_sum));
                    frame_sum = 0;
                    pending   = 1'b1;
                    res_at    = free_at;
                end
            end
        end
        t++;
    end

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W0-1:0] d, input logic l, output int acc_cyc);
        int k = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("accept_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 60);
        if (!bus.out_valid) chk("result_timeout", bus.out_valid, 1'b1);
    endtask

    // ---------------- main directed sequence ----------------
    logic [7:0] tw[6] = '{8'h80, 8'hAA, 8'h55, 8'h01, 8'h02, 8'h04};
    logic       tl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int         tex[3] = '{1, 8, 3};

    initial begin
        int lat, t0, t1, t2, k, fi;
        reset = 1'b1;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_count", bus.out_count, 16'd0);
        chk("rst_out_overflow", bus.out_overflow, 1'b0);
        sync();

        // Single word 0xFF, last: result in cycle N+1 = 5
        send_word(8'hFF, 1'b1, t0);
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("t1_latency", lat, 5);
        chk("t1_count", bus.out_count, 16'd8);
        chk("t1_overflow", bus.out_overflow, 1'b0);
        sync();

        // Three-word frame with in_valid held high: accepts every 5 cycles
        send_word(8'h0F, 1'b0, t0);
        send_word(8'h01, 1'b0, t1);
        send_word(8'h00, 1'b1, t2);
        bus.in_valid = 1'b0;
        chk("t2_spacing_a", t1 - t0, 5);
        chk("t2_spacing_b", t2 - t1, 5);
        wait_out(lat);
        chk("t2_count", bus.out_count, 16'd5);
        sync();

        // Backpressure on a pending result
        bus.out_ready = 1'b0;
        send_word(8'hA5, 1'b1, t0);
        bus.in_valid = 1'b0;
        wait_out(lat);
        repeat (10) begin
            @(negedge clk);
            chk("t3_hold_count", bus.out_count, 16'd4);
            chk("t3_hold_ovf", bus.out_overflow, 1'b0);
            chk("t3_hold_in_ready", bus.in_ready, 1'b0);
        end
        sync();
        bus.out_ready = 1'b1;
        sync();
        @(negedge clk);
        chk("t3_release_out_valid", bus.out_valid, 1'b0);
        chk("t3_release_in_ready", bus.in_ready, 1'b1);
        sync();

        // Overflow on the ACC_W=4 instance: 8 + 8 set bits
        bus1.in_data = 8'hFF; bus1.in_last = 1'b0; bus1.in_valid = 1'b1;
        sync();
        bus1.in_last = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus1.in_ready && k < 40);
        sync();
        bus1.in_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus1.out_valid && k < 40);
        chk("t4_out_valid", bus1.out_valid, 1'b1);
`ifdef POPCNT_SATURATE_EN
        chk("t4_count", bus1.out_count, 4'd15);
`else
        chk("t4_count", bus1.out_count, 4'd0);
`endif
        chk("t4_overflow", bus1.out_overflow, 1'b1);
        sync();

        // Reset in the 2nd SCAN cycle discards the partial frame
        send_word(8'hFF, 1'b1, t0);
        bus.in_valid = 1'b0;
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", bus.in_ready, 1'b1);
        chk("t5_out_count_cleared", bus.out_count, 16'd0);
        sync();
        send_word(8'h03, 1'b1, t0);
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("t5_count", bus.out_count, 16'd2);
        chk("t5_overflow", bus.out_overflow, 1'b0);
        sync();

        // Table of short frames, including a lone single-bit word
        fi = 0;
        for (int i = 0; i < 6; i++) begin
            send_word(tw[i], tl[i], t0);
            if (tl[i]) begin
                bus.in_valid = 1'b0;
                wait_out(lat);
                chk($sformatf("t6_frame%0d_count", fi), bus.out_count, 64'(tex[fi]));
                fi++;
                sync();
            end
        end

        k = 0;
        while (sweep_left > 0 && k < 40000) begin
            @(posedge clk);
            k++;
        end
        if (sweep_left > 0) chk("sweep_timeout", sweep_left, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- parameter sweep ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 32 : 8;
        localparam int SL = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
        localparam int SN = SW / SL;
        logic sreset;

        popcount_stream_acc_if #(.WIDTH(SW), .ACC_W(16)) sbus ();
        popcount_stream_acc #(.WIDTH(SW), .LANES(SL), .ACC_W(16)) sdut (
            .clk(clk), .reset(sreset), .bus(sbus.slave)
        );

        initial begin
            int nw, sum, lat, k;
            logic [SW-1:0] d;
            sbus.in_valid = 1'b0; sbus.in_last = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b1;
            sreset = 1'b1;
            repeat (3) @(posedge clk);
            #1 sreset = 1'b0;
            for (int f = 0; f < 120; f++) begin
                nw  = $urandom_range(1, 4);
                sum = 0;
                for (int w = 0; w < nw; w++) begin
                    d = SW'($urandom);
                    if ($urandom_range(0, 7) == 0) d = '0;
                    sum += $countones(d);
                    sbus.in_data  = d;
                    sbus.in_last  = (w == nw - 1);
                    sbus.in_valid = 1'b1;
                    k = 0;
                    while (!sbus.in_ready && k < 50) begin
                        @(negedge clk);
                        k++;
                    end
                    @(posedge clk);
                    #1 sbus.in_valid = 1'b0;
                    lat = 0;
                    do begin
                        @(negedge clk);
                        lat++;
                    end while (!(sbus.in_last ? sbus.out_valid : sbus.in_ready) && lat < 50);
                    chk($sformatf("sweep%0d_latency", g), lat, SN + 1);
                    if (sbus.in_last) begin
                        chk($sformatf("sweep%0d_count", g), sbus.out_count, 64'(sum));
                        chk($sformatf("sweep%0d_overflow", g), sbus.out_overflow, 1'b0);
                    end
                end
            end
            sweep_left--;
        end
    end

endmodule
